// File: rtl/dram_arb_if.sv
// Bus bundle between two DRAM masters, the arbiter and a single-port data RAM.
// The bus uses zero-cycle request/grant. A master holds req, we, addr, wdata, wstrb and lock
// stable until it sees gnt=1. A beat transfers on the rising edge where req=1 and gnt=1.
// Read data returns with rvalid exactly one cycle later.
interface dram_arb_if #(
  parameter int ADDR_W = 14
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [31:0]       m0_wdata;
  logic [3:0]        m0_wstrb;
  logic              m0_lock;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [31:0]       m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [31:0]       m1_wdata;
  logic [3:0]        m1_wstrb;
  logic              m1_lock;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [31:0]       m1_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_wstrb;
  logic [31:0]       ram_rdata;
  logic              owner;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb, m0_lock,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb, m1_lock,
    input  ram_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata, ram_wstrb, owner
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb, m0_lock,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb, m1_lock,
    output ram_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata, ram_wstrb, owner
  );
endinterface

// File: rtl/dram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port data RAM, with 1-cycle read return.
// Define DRAM_ARB_LOCK_EN to honour mN_lock (bounded by LOCK_MAX beats); otherwise lock is ignored.
module dram_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int LOCK_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  dram_arb_if.slave  bus,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t r_state;
  logic   r_last;
  logic   r_owner;
  logic   r_rv0;
  logic   r_rv1;
  logic   w_hold;
  logic   w_gnt0;
  logic   w_gnt1;

`ifdef DRAM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic             r_locked;
  logic [CNT_W-1:0] r_cnt;
  logic             w_own_req;
  logic             w_own_lock;
  logic             w_lock_in;
  logic             w_same;

  assign w_own_req  = (r_state == OWN1) ? bus.m1_req  : bus.m0_req;
  assign w_own_lock = (r_state == OWN1) ? bus.m1_lock : bus.m0_lock;
  assign w_lock_in  = w_gnt1 ? bus.m1_lock : bus.m0_lock;
  assign w_same     = (w_gnt1 ? OWN1 : OWN0) == r_state;

  // Lock lapses once the owner goes quiet with lock=0, or after LOCK_MAX locked beats.
  assign w_hold = r_locked && (r_state != IDLE) && (w_own_req || w_own_lock) &&
                  (r_cnt < CNT_W'(LOCK_MAX));
`else
  logic w_unused_lock;

  assign w_unused_lock = bus.m0_lock ^ bus.m1_lock;
  assign w_hold        = 1'b0;
`endif

  // r_last=1 means m1 won most recently, so m0 wins the next conflict.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      if (w_hold) begin
        if (r_state == OWN0) w_gnt0 = bus.m0_req;
        else                 w_gnt1 = bus.m1_req;
      end else if (bus.m0_req && bus.m1_req) begin
        if (r_last) w_gnt0 = 1'b1;
        else        w_gnt1 = 1'b1;
      end else begin
        w_gnt0 = bus.m0_req;
        w_gnt1 = bus.m1_req;
      end
    end
  end

  assign bus.m0_gnt = w_gnt0;
  assign bus.m1_gnt = w_gnt1;
  assign bus.ram_en = w_gnt0 | w_gnt1;

  always_comb begin
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.ram_wstrb = '0;
    if (w_gnt0) begin
      bus.ram_we    = bus.m0_we;
      bus.ram_addr  = bus.m0_addr;
      bus.ram_wdata = bus.m0_wdata;
      bus.ram_wstrb = bus.m0_wstrb;
    end else if (w_gnt1) begin
      bus.ram_we    = bus.m1_we;
      bus.ram_addr  = bus.m1_addr;
      bus.ram_wdata = bus.m1_wdata;
      bus.ram_wstrb = bus.m1_wstrb;
    end
  end

  // Gating with rst drops a read that was granted just before reset.
  assign bus.m0_rvalid = r_rv0 & ~rst;
  assign bus.m1_rvalid = r_rv1 & ~rst;
  assign bus.m0_rdata  = bus.m0_rvalid ? bus.ram_rdata : 32'd0;
  assign bus.m1_rdata  = bus.m1_rvalid ? bus.ram_rdata : 32'd0;
  assign bus.owner     = r_owner & ~rst;
  assign o_state       = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_rv0    <= 1'b0;
      r_rv1    <= 1'b0;
`ifdef DRAM_ARB_LOCK_EN
      r_locked <= 1'b0;
      r_cnt    <= '0;
`endif
    end else begin
      r_rv0 <= w_gnt0 & ~bus.m0_we;
      r_rv1 <= w_gnt1 & ~bus.m1_we;
      if (w_gnt0 || w_gnt1) begin
        r_state <= w_gnt1 ? OWN1 : OWN0;
        r_last  <= w_gnt1;
        r_owner <= w_gnt1;
`ifdef DRAM_ARB_LOCK_EN
        if (w_lock_in) begin
          r_locked <= 1'b1;
          if (w_same && (r_cnt < CNT_W'(LOCK_MAX))) r_cnt <= r_cnt + CNT_W'(1);
          else                                      r_cnt <= CNT_W'(1);
        end else begin
          r_locked <= 1'b0;
          r_cnt    <= '0;
        end
`endif
      end else if (!w_hold) begin
        r_state  <= IDLE;
`ifdef DRAM_ARB_LOCK_EN
        r_locked <= 1'b0;
        r_cnt    <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios plus randomized traffic against a reference model.
// Build with +define+DRAM_ARB_LOCK_EN to check the locked-ownership behaviour.
module tb_dram_arbiter;
  localparam int ADDR_W   = 14;
  localparam int LOCK_MAX = 16;
`ifdef DRAM_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  dram_arb_if #(.ADDR_W(ADDR_W)) bus ();

  dram_arbiter #(.ADDR_W(ADDR_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // master-side stimulus
  logic              req[2];
  logic              we[2];
  logic [ADDR_W-1:0] addr[2];
  logic [31:0]       wdata[2];
  logic [3:0]        wstrb[2];
  logic              lock[2];

  assign bus.m0_req   = req[0];
  assign bus.m0_we    = we[0];
  assign bus.m0_addr  = addr[0];
  assign bus.m0_wdata = wdata[0];
  assign bus.m0_wstrb = wstrb[0];
  assign bus.m0_lock  = lock[0];
  assign bus.m1_req   = req[1];
  assign bus.m1_we    = we[1];
  assign bus.m1_addr  = addr[1];
  assign bus.m1_wdata = wdata[1];
  assign bus.m1_wstrb = wstrb[1];
  assign bus.m1_lock  = lock[1];

  function automatic logic [31:0] init_word(input int i);
    return (i == 5) ? 32'hDEADBEEF : (32'hA500_0000 | (32'(i) * 32'h0101));
  endfunction

  // RAM model, driven purely by the DUT's RAM port; junk on ram_rdata when no read
  logic [31:0] ram_mem[16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= init_word(i);
      bus.ram_rdata <= $urandom();
    end else if (bus.ram_en && bus.ram_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_wstrb[b]) ram_mem[bus.ram_addr[3:0]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      bus.ram_rdata <= $urandom();
    end else if (bus.ram_en) begin
      bus.ram_rdata <= ram_mem[bus.ram_addr[3:0]];
    end else begin
      bus.ram_rdata <= $urandom();
    end
  end

  // reference model and scoreboard
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        m_last;
  logic        m_owner;
  int          holder;
  int          cnt;
  logic        gprev[2];
  logic        obs_g0;
  logic        obs_g1;
  logic [31:0] ref_mem[16];
  logic [32:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int n, input logic r, input logic w, input int a,
                       input logic [31:0] d, input logic [3:0] s, input logic l);
    req[n]   = r;
    we[n]    = w;
    addr[n]  = ADDR_W'(a);
    wdata[n] = d;
    wstrb[n] = s;
    lock[n]  = l;
  endtask

  // A master may only change its request once the previous one was accepted.
  task automatic rand_master(input int n, input int pct);
    if (!req[n] || gprev[n])
      set_m(n, $urandom_range(0, 99) < pct, $urandom_range(0, 1), $urandom_range(0, 15),
            $urandom(), 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
  endtask

  // Called just after a falling edge once inputs are set: checks, then advances the model.
  task automatic cycle();
    logic        e0, e1, held, ev0, ev1, g;
    logic [32:0] ent;
    logic [31:0] ed;
    #1;
    e0   = 1'b0;
    e1   = 1'b0;
    held = LOCK_EN && holder >= 0 && cnt < LOCK_MAX && (req[holder] || lock[holder]);
    if (!rst) begin
      if (held)                  begin e0 = (holder == 0) && req[0]; e1 = (holder == 1) && req[1]; end
      else if (req[0] && req[1]) begin e0 = m_last; e1 = !m_last; end
      else                       begin e0 = req[0]; e1 = req[1]; end
    end
    ev0 = 1'b0;
    ev1 = 1'b0;
    ed  = 32'd0;
    if (exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      ev0 = !rst && !ent[32];
      ev1 = !rst && ent[32];
      ed  = ent[31:0];
    end
    obs_g0 = bus.m0_gnt;
    obs_g1 = bus.m1_gnt;
    chk("m0_gnt", 32'(bus.m0_gnt), 32'(e0));
    chk("m1_gnt", 32'(bus.m1_gnt), 32'(e1));
    chk("ram_en", 32'(bus.ram_en), 32'(e0 | e1));
    chk("m0_rvalid", 32'(bus.m0_rvalid), 32'(ev0));
    chk("m1_rvalid", 32'(bus.m1_rvalid), 32'(ev1));
    chk("m0_rdata", bus.m0_rdata, ev0 ? ed : 32'd0);
    chk("m1_rdata", bus.m1_rdata, ev1 ? ed : 32'd0);
    chk("owner", 32'(bus.owner), rst ? 32'd0 : 32'(m_owner));
    g = e1;
    if (e0 || e1) begin
      chk("ram_we", 32'(bus.ram_we), 32'(we[g]));
      chk("ram_addr", 32'(bus.ram_addr), 32'(addr[g]));
      chk("ram_wdata", bus.ram_wdata, wdata[g]);
      chk("ram_wstrb", 32'(bus.ram_wstrb), 32'(wstrb[g]));
    end else if (rst) begin
      chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
      chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    end
    if (rst) begin
      m_last  = 1'b1;
      m_owner = 1'b0;
      holder  = -1;
      cnt     = 0;
      exp_q.delete();
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    end else if (e0 || e1) begin
      if (!we[g]) exp_q.push_back({g, ref_mem[addr[g][3:0]]});
      else
        for (int b = 0; b < 4; b++)
          if (wstrb[g][b]) ref_mem[addr[g][3:0]][8*b +: 8] = wdata[g][8*b +: 8];
      if (LOCK_EN && lock[g]) begin
        cnt    = (holder == int'(g) && cnt < LOCK_MAX) ? cnt + 1 : 1;
        holder = int'(g);
      end else begin
        holder = -1;
        cnt    = 0;
      end
      m_last  = g;
      m_owner = g;
    end else if (!held) begin
      holder = -1;
      cnt    = 0;
    end
    gprev[0] = e0;
    gprev[1] = e1;
  endtask

  task automatic idle_all();
    set_m(0, 1'b0, 1'b0, 0, 32'd0, 4'd0, 1'b0);
    set_m(1, 1'b0, 1'b0, 0, 32'd0, 4'd0, 1'b0);
  endtask

  int m1_beats, m1_before, resume_who;
  logic seen_m0;

  initial begin
    gprev[0] = 1'b0;
    gprev[1] = 1'b0;
    idle_all();

    // reset with traffic present: everything must stay quiet
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rand_master(0, 80);
      rand_master(1, 80);
      cycle();
    end
    @(negedge clk);
    idle_all();
    cycle();
    rst = 1'b0;

    // lone m0 read of address 5
    @(negedge clk);
    set_m(0, 1'b1, 1'b0, 5, 32'd0, 4'd0, 1'b0);
    cycle();
    chk("r035_gnt", 32'(bus.m0_gnt), 32'd1);
    @(negedge clk);
    idle_all();
    cycle();
    chk("r035_rdata", bus.m0_rdata, 32'hDEADBEEF);
    chk("r035_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);

    // lone m1 write
    @(negedge clk);
    set_m(1, 1'b1, 1'b1, 1, 32'h34, 4'hF, 1'b0);
    cycle();
    chk("r037_we", 32'(bus.ram_we), 32'd1);
    chk("r037_wdata", bus.ram_wdata, 32'h34);
    @(negedge clk);
    idle_all();
    cycle();

    // m1 locked burst of 20 beats while m0 keeps asking
    m1_beats   = 0;
    m1_before  = 0;
    resume_who = -1;
    seen_m0    = 1'b0;
    for (int k = 0; k < 200 && m1_beats < 20; k++) begin
      @(negedge clk);
      if (k == 0 || gprev[1])
        set_m(1, 1'b1, 1'b1, $urandom_range(0, 15), $urandom(), 4'hF, m1_beats < 19);
      if (k == 1 || (k > 1 && gprev[0]))
        set_m(0, 1'b1, 1'b0, $urandom_range(0, 15), 32'd0, 4'd0, 1'b0);
      cycle();
      if (seen_m0 && resume_who < 0 && (obs_g0 || obs_g1)) resume_who = obs_g1 ? 1 : 0;
      if (obs_g1) begin
        m1_beats++;
        if (!seen_m0) m1_before++;
      end
      if (obs_g0) seen_m0 = 1'b1;
    end
    chk("burst_len", 32'(m1_beats), 32'd20);
    chk("burst_m1_before_m0", 32'(m1_before), LOCK_EN ? 32'(LOCK_MAX) : 32'd1);
    chk("burst_resume", 32'(resume_who), 32'd1);
    @(negedge clk);
    idle_all();
    cycle();

    // randomized mixed traffic
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      rand_master(0, 70);
      rand_master(1, 70);
      cycle();
    end
    for (int k = 0; k < 24 && (req[0] || req[1]); k++) begin
      @(negedge clk);
      if (gprev[0]) req[0] = 1'b0;
      if (gprev[1]) req[1] = 1'b0;
      lock[0] = 1'b0;
      lock[1] = 1'b0;
      cycle();
    end

    // reset right after a granted m0 read, then both request continuously
    @(negedge clk);
    idle_all();
    set_m(0, 1'b1, 1'b0, 3, 32'd0, 4'd0, 1'b0);
    cycle();
    @(negedge clk);
    idle_all();
    rst = 1'b1;
    cycle();
    chk("r040_no_rvalid", 32'(bus.m0_rvalid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      for (int n = 0; n < 2; n++)
        if (k == 0 || gprev[n]) set_m(n, 1'b1, 1'b0, $urandom_range(0, 15), 32'd0, 4'd0, 1'b0);
      cycle();
      chk("alt_who", obs_g1 ? 32'd1 : 32'd0, 32'(k % 2));
      chk("alt_one_hot", 32'(obs_g0 + obs_g1), 32'd1);
    end
    @(negedge clk);
    idle_all();
    cycle();
    @(negedge clk);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, data RAM word-address width.
REQ-002 Parameter LOCK_MAX, default 16, maximum consecutive locked beats per ownership.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 mN_req  input  1  request from master N (N=0 CPU load/store, N=1 DMA/loader).
REQ-006 mN_we  input  1  write (1) or read (0).
REQ-007 mN_addr  input  ADDR_W  word address.
REQ-008 mN_wdata  input  32  write data.
REQ-009 mN_wstrb  input  4  byte enables for writes.
REQ-010 mN_lock  input  1  hold ownership after this beat.
REQ-011 mN_gnt  output  1  request accepted this cycle.
REQ-012 mN_rvalid  output  1  read data valid for master N.
REQ-013 mN_rdata  output  32  read data.
REQ-014 ram_en, ram_we  output  1 each  RAM access strobes.
REQ-015 ram_addr  output  ADDR_W;  ram_wdata  output  32;  ram_wstrb  output  4.
REQ-016 ram_rdata  input  32  RAM read data, valid one cycle after ram_en with ram_we=0.
REQ-017 owner  output  1  master currently granted or last granted.

Function
REQ-018 A transfer SHALL occur on a rising edge where mN_req=1 and mN_gnt=1; mN_gnt SHALL be combinational from req and registered state (zero-cycle grant).
REQ-019 Masters SHALL hold req, we, addr, wdata, wstrb stable until gnt; arbiter SHALL NOT require req deassertion between beats.
REQ-020 At most one mN_gnt SHALL be high per cycle; ram_en SHALL equal OR of the grants; ram_we/addr/wdata/wstrb SHALL mux from the granted master.
REQ-021 FSM states IDLE, OWN0, OWN1; IDLE→OWNn on grant to n; OWNn→IDLE when owner not locked and no grant; OWNn→OWNm on grant to m.
REQ-022 Single requester SHALL be granted immediately when not blocked by lock.
REQ-023 Both requesting, no lock: grant the master not granted last (round-robin); last-grant register updated on every grant.
REQ-024 Read latency SHALL be exactly 1 cycle: mN_rvalid=1 and mN_rdata=ram_rdata in the cycle after a granted read by N; writes produce no rvalid.
REQ-025 mN_rdata SHALL be 0 when mN_rvalid=0.
REQ-026 Back-to-back reads (same or alternating masters) SHALL sustain one beat per cycle, each rvalid routed to its originator.
REQ-027 owner SHALL reflect the FSM owner (OWN1→1, OWN0→0, IDLE→last granted).

Reset
REQ-028 With rst=1 at an edge: FSM→IDLE, last-grant→1 (m0 wins first conflict), lock counter→0, read pipeline cleared.
REQ-029 During and after reset cycle all outputs SHALL be 0; a read granted in the cycle before reset SHALL return no rvalid.
REQ-030 Grants SHALL be suppressed while rst=1.

Configuration
REQ-031 Macro DRAM_ARB_LOCK_EN: defined → lock honoured; undefined → mN_lock ignored, pure round-robin per REQ-023.
REQ-032 With lock: a granted beat with mN_lock=1 keeps OWNn; other master's gnt held 0 until owner completes a beat with lock=0, or owner cycle with req=0 and lock=0.
REQ-033 With lock: counter counts consecutive locked beats; at LOCK_MAX the lock is forcibly broken, other master (if requesting) granted next cycle, counter cleared.
REQ-034 Counter SHALL clear on any unlocked beat or ownership change.

Verification
REQ-035 m0 read addr 5 alone, ram_rdata=0xDEADBEEF next cycle → m0_gnt same cycle, m0_rvalid=1 with 0xDEADBEEF one cycle later, m1_rvalid=0.
REQ-036 Both request continuously from reset → grants alternate m0,m1,m0,m1; never both high.
REQ-037 m1 write 0x34 addr 1 strobe 0xF while m0 idle → ram_we=1, ram_addr=1, ram_wdata=0x34, no rvalid.
REQ-038 Lock enabled, m1 locked burst of 20 beats with m0 requesting → m1 gets 16 beats, m0 granted on 17th cycle, m1 resumes after.
REQ-039 Lock disabled, same stimulus → strict alternation, m1_lock without effect.
REQ-040 Reset asserted the cycle after a granted m0 read → no m0_rvalid, all outputs 0, first post-reset conflict grants m0.
